// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-controller bus; master = pipeline side driving status, slave = controller returning strobes
interface pipe_hazard_if;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic        use_rs_D;
  logic        use_rt_D;
  logic        hilo_use_D;
  logic        load_E;
  logic [4:0]  WBA_E;
  logic        md_start_E;
  logic        md_div_E;
  logic [8:0]  MEM_Out_EXC;
  logic        eret_M;
  logic [31:0] debug_pc_M;
  logic        stall_F;
  logic        stall_D;
  logic        flush_D;
  logic        flush_E;
  logic        flush_M;
  logic        flush_W;
  logic [1:0]  pc_sel;
  logic        md_busy;
  logic [8:0]  exc_cause_q;
  logic [31:0] epc_q;
  logic        exc_valid_q;
  logic [31:0] perf_stall_cnt;
  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, hilo_use_D, load_E, WBA_E, md_start_E, md_div_E,
           MEM_Out_EXC, eret_M, debug_pc_M,
    input  stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, pc_sel, md_busy,
           exc_cause_q, epc_q, exc_valid_q, perf_stall_cnt
  );
  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, hilo_use_D, load_E, WBA_E, md_start_E, md_div_E,
           MEM_Out_EXC, eret_M, debug_pc_M,
    output stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, pc_sel, md_busy,
           exc_cause_q, epc_q, exc_valid_q, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush sequencer (load-use, HI/LO busy, exception/ERET); PIPE_PERF_CNT_EN adds a stall counter
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic rst,
  pipe_hazard_if.slave hz
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_busy;
  logic [8:0]       r_cause;
  logic [31:0]      r_epc;
  logic             r_valid;
  logic w_run, w_exc, w_trap, w_md_stall, w_lu, w_stall, w_start;
  always_comb begin
    w_run      = !rst && r_state == RUN;
    w_exc      = |hz.MEM_Out_EXC;
    w_trap     = w_run && (w_exc || hz.eret_M);
    w_md_stall = r_busy != '0 && hz.hilo_use_D;
    w_lu       = hz.load_E && hz.WBA_E != 5'd0 &&
                 ((hz.use_rs_D && hz.rs_D == hz.WBA_E) || (hz.use_rt_D && hz.rt_D == hz.WBA_E));
    w_stall    = w_run && !w_trap && (w_md_stall || w_lu);
    w_start    = w_run && !w_trap && hz.md_start_E;
  end
  assign hz.stall_F     = w_stall;
  assign hz.stall_D     = w_stall;
  assign hz.flush_D     = w_trap;
  assign hz.flush_E     = w_trap || w_stall;
  assign hz.flush_M     = w_trap;
  assign hz.flush_W     = w_trap;
  assign hz.pc_sel      = !w_trap ? 2'd0 : w_exc ? 2'd1 : 2'd2;
  assign hz.md_busy     = r_busy != '0;
  assign hz.exc_cause_q = r_cause;
  assign hz.epc_q       = r_epc;
  assign hz.exc_valid_q = r_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_busy  <= '0;
      r_cause <= '0;
      r_epc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_trap ? DRAIN : RUN;
      // HI/LO result still commits on an exception, so the counter keeps running
      if (w_start)
        r_busy <= hz.md_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (r_busy != '0)
        r_busy <= r_busy - 1'b1;
      r_valid <= w_trap && w_exc;
      if (w_trap && w_exc) begin
        r_cause <= hz.MEM_Out_EXC;
        r_epc   <= hz.debug_pc_M;
      end
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_perf <= '0;
    else     r_perf <= r_perf + {31'd0, w_stall};
  end
  assign hz.perf_stall_cnt = r_perf;
`else
  assign hz.perf_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_hazard_if hz ();
  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int m_busy_left;
  bit m_after_trap;
  logic [8:0]  m_cause;
  logic [31:0] m_epc;
  bit          m_valid;
  logic [31:0] m_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hz.rs_D = 0; hz.rt_D = 0; hz.use_rs_D = 0; hz.use_rt_D = 0; hz.hilo_use_D = 0;
    hz.load_E = 0; hz.WBA_E = 0; hz.md_start_E = 0; hz.md_div_E = 0;
    hz.MEM_Out_EXC = 0; hz.eret_M = 0; hz.debug_pc_M = 0;
  endtask

  task automatic model_reset();
    m_busy_left = 0; m_after_trap = 0; m_cause = 0; m_epc = 0; m_valid = 0; m_perf = 0;
  endtask

  task automatic chk_regs();
    chk("md_busy", {31'd0, hz.md_busy}, {31'd0, m_busy_left > 0});
    chk("exc_valid_q", {31'd0, hz.exc_valid_q}, {31'd0, m_valid});
    if (m_valid) begin
      chk("exc_cause_q", {23'd0, hz.exc_cause_q}, {23'd0, m_cause});
      chk("epc_q", hz.epc_q, m_epc);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_cnt", hz.perf_stall_cnt, m_perf);
`else
    chk("perf_stall_cnt", hz.perf_stall_cnt, 32'd0);
`endif
  endtask

  // Inputs are already applied; check combinational strobes, clock once, update model, check registers.
  task automatic cycle();
    bit trap, exc, hazard, stall, lu;
    logic [1:0] sel;
    #2;
    exc    = hz.MEM_Out_EXC != 0;
    trap   = !m_after_trap && (exc || hz.eret_M);
    lu     = hz.load_E && hz.WBA_E != 0 &&
             ((hz.use_rs_D && hz.rs_D == hz.WBA_E) || (hz.use_rt_D && hz.rt_D == hz.WBA_E));
    hazard = (m_busy_left > 0 && hz.hilo_use_D) || lu;
    stall  = !m_after_trap && !trap && hazard;
    sel    = trap ? (exc ? 2'd1 : 2'd2) : 2'd0;
    chk("stall_F", {31'd0, hz.stall_F}, {31'd0, stall});
    chk("stall_D", {31'd0, hz.stall_D}, {31'd0, stall});
    chk("flush_D", {31'd0, hz.flush_D}, {31'd0, trap});
    chk("flush_E", {31'd0, hz.flush_E}, {31'd0, trap || stall});
    chk("flush_M", {31'd0, hz.flush_M}, {31'd0, trap});
    chk("flush_W", {31'd0, hz.flush_W}, {31'd0, trap});
    chk("pc_sel", {30'd0, hz.pc_sel}, {30'd0, sel});
    @(posedge clk);
    #1;
    if (!m_after_trap && !trap && hz.md_start_E) m_busy_left = hz.md_div_E ? 10 : 5;
    else if (m_busy_left > 0) m_busy_left--;
    m_valid = trap && exc;
    if (trap && exc) begin m_cause = hz.MEM_Out_EXC; m_epc = hz.debug_pc_M; end
    m_after_trap = trap;
    if (stall) m_perf++;
    chk_regs();
  endtask

  initial begin
    clr();
    model_reset();
    hz.load_E = 1; hz.WBA_E = 5; hz.rs_D = 5; hz.use_rs_D = 1;
    #2;
    chk("rst_stall_D", {31'd0, hz.stall_D}, 32'd0);
    chk("rst_flush_E", {31'd0, hz.flush_E}, 32'd0);
    chk("rst_pc_sel", {30'd0, hz.pc_sel}, 32'd0);
    chk_regs();
    @(negedge clk); rst = 0; clr();
    @(negedge clk);
    // load-use: three single-cycle stalls, then none with WBA_E=0
    for (int i = 0; i < 3; i++) begin
      hz.load_E = 1; hz.WBA_E = 5'd5 + 5'(i); hz.rs_D = 5'd5 + 5'(i); hz.use_rs_D = 1;
      cycle(); clr(); cycle();
    end
    hz.load_E = 1; hz.WBA_E = 0; hz.rt_D = 0; hz.use_rt_D = 1; cycle(); clr();
    // MULT then MFLO held in D: 5 stall cycles, released on the 6th
    hz.md_start_E = 1; cycle(); clr();
    hz.hilo_use_D = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("mult_released", {31'd0, hz.md_busy}, 32'd0);
    clr();
    // exception
    hz.MEM_Out_EXC = 9'h010; hz.debug_pc_M = 32'hBFC00100; cycle(); clr();
    chk("exc_epc", hz.epc_q, 32'hBFC00100);
    hz.MEM_Out_EXC = 9'h004; hz.eret_M = 1; cycle(); clr();
    cycle();
    // exception and ERET together, then ERET alone
    hz.MEM_Out_EXC = 9'h020; hz.eret_M = 1; hz.debug_pc_M = 32'h80000040; cycle(); clr(); cycle();
    hz.eret_M = 1; cycle(); clr(); cycle();
    // exception during DIV busy
    hz.md_start_E = 1; hz.md_div_E = 1; cycle(); clr();
    cycle(); cycle();
    hz.MEM_Out_EXC = 9'h001; hz.debug_pc_M = 32'h00400010; cycle(); clr();
    for (int i = 0; i < 8; i++) cycle();
    chk("div_done", {31'd0, hz.md_busy}, 32'd0);
    // async reset mid-DIV with busy_cnt=6
    hz.md_start_E = 1; hz.md_div_E = 1; cycle(); clr();
    for (int i = 0; i < 4; i++) cycle();
    chk("div_busy_before_rst", {31'd0, hz.md_busy}, 32'd1);
    hz.hilo_use_D = 1; hz.load_E = 1; hz.WBA_E = 3; hz.rt_D = 3; hz.use_rt_D = 1;
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_md_busy", {31'd0, hz.md_busy}, 32'd0);
    chk("arst_stall_F", {31'd0, hz.stall_F}, 32'd0);
    chk("arst_flush_E", {31'd0, hz.flush_E}, 32'd0);
    chk_regs();
    @(negedge clk); rst = 0; clr();
    @(negedge clk);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      hz.rs_D = 5'($urandom_range(0, 3)); hz.rt_D = 5'($urandom_range(0, 3));
      hz.use_rs_D = 1'($urandom); hz.use_rt_D = 1'($urandom);
      hz.hilo_use_D = 1'($urandom); hz.load_E = 1'($urandom);
      hz.WBA_E = 5'($urandom_range(0, 3));
      hz.md_start_E = $urandom_range(0, 9) == 0; hz.md_div_E = 1'($urandom);
      hz.MEM_Out_EXC = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(1, 511)) : 9'd0;
      hz.eret_M = $urandom_range(0, 15) == 0;
      hz.debug_pc_M = $urandom;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
